// File: rtl/sev_seg_scan_ctrl.sv
// rtl/sev_seg_scan_ctrl.sv - Multiplexed 7-segment scan controller with double-buffered value
module sev_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    typedef enum logic {BLANK, ON} state_t;

    state_t                state, nxt_state;
    logic [CW-1:0]         slot_cnt, nxt_slot;
    logic [IW-1:0]         idx, nxt_idx;
    logic [VW-1:0]         disp_val, nxt_disp_val, shadow;
    logic [NUM_DIGITS-1:0] disp_dp, nxt_disp_dp, shadow_dp;
    logic [NUM_DIGITS-1:0] nxt_an;
    logic [6:0]            nxt_seg;
    logic                  nxt_dp;
    logic                  slot_end, wrap, commit;
    logic [3:0]            sel_nib;
    logic                  sel_dp, sel_blank, zero_run;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Next slot position, commit decision and the outputs of the state being entered
    always_comb begin
        slot_end     = (slot_cnt == CW'(REFRESH_DIV - 1));
        wrap         = slot_end && (idx == IW'(NUM_DIGITS - 1));
        commit       = wrap && pending;
        nxt_slot     = slot_cnt + 1'b1;
        nxt_idx      = idx;
        nxt_state    = state;
        if (slot_end) begin
            nxt_slot  = '0;
            nxt_idx   = wrap ? '0 : idx + 1'b1;
            nxt_state = BLANK;
        end else if (state == BLANK && slot_cnt == CW'(BLANK_CYCLES - 1)) begin
            nxt_state = ON;
        end
        nxt_disp_val = commit ? shadow : disp_val;
        nxt_disp_dp  = commit ? shadow_dp : disp_dp;

        // Walk from the top digit down so zero_run says "this digit and all above are 0"
        sel_nib   = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        zero_run  = 1'b1;
        nxt_an    = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (nxt_disp_val[4*k +: 4] == 4'h0);
            if (nxt_idx == IW'(k)) begin
                sel_nib   = nxt_disp_val[4*k +: 4];
                sel_dp    = nxt_disp_dp[k];
                sel_blank = lz_en && zero_run && (k != 0);
                nxt_an[k] = (nxt_state != ON);
            end
        end
        nxt_seg = 7'h7F;
        nxt_dp  = 1'b1;
        if (nxt_state == ON) begin
            nxt_seg = sel_blank ? 7'h7F : hex7(sel_nib);
            nxt_dp  = ~sel_dp;
        end
    end

    // Scan state, double buffer and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            slot_cnt   <= '0;
            idx        <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            state      <= nxt_state;
            slot_cnt   <= nxt_slot;
            idx        <= nxt_idx;
            disp_val   <= nxt_disp_val;
            disp_dp    <= nxt_disp_dp;
            frame_done <= wrap;
            an         <= nxt_an;
            seg        <= nxt_seg;
            dp         <= nxt_dp;
            if (load) begin
                shadow    <= value;
                shadow_dp <= dp_in;
                pending   <= 1'b1;
            end else if (commit) begin
                pending   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// tb/tb_sev_seg_scan_ctrl.sv - Scoreboard bench for sev_seg_scan_ctrl against a frame-position model
module tb_sev_seg_scan_ctrl;

    localparam int ND  = 4;
    localparam int DIV = 8;
    localparam int BLK = 2;
    localparam int TOT = ND * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0]  dec [16];
    logic [13:0] exp_q[$];

    int          m_pos;
    logic [15:0] m_disp, m_sh;
    logic [3:0]  m_ddp, m_shdp;
    logic        m_pend;

    sev_seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lz_en(lz_en),
        .an(an), .seg(seg), .dp(dp), .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Expected outputs after a clock edge, derived from the frame position
    task automatic model_step(input logic r, input logic ld, input logic [15:0] v,
                              input logic [3:0] d, input logic lz);
        logic fd;
        int di, sl;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        fd = 1'b0;
        if (r) begin
            m_pos = 0; m_disp = '0; m_ddp = '0; m_sh = '0; m_shdp = '0; m_pend = 1'b0;
        end else begin
            if (m_pos == TOT - 1) begin
                fd = 1'b1;
                if (m_pend) begin
                    m_disp = m_sh; m_ddp = m_shdp; m_pend = 1'b0;
                end
            end
            if (ld) begin
                m_sh = v; m_shdp = d; m_pend = 1'b1;
            end
            m_pos = (m_pos + 1) % TOT;
        end
        di = m_pos / DIV;
        sl = m_pos % DIV;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (sl >= BLK) begin
            e_an[di] = 1'b0;
            e_dp = ~m_ddp[di];
            if (lz && di > 0 && (m_disp >> (4 * di)) == 16'h0) e_seg = 7'h7F;
            else e_seg = dec[(m_disp >> (4 * di)) & 16'hF];
        end
        exp_q.push_back({e_an, e_seg, e_dp, m_pend, fd});
    endtask

    task automatic tick(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
        rst = r; load = ld; value = v; dp_in = d;
        @(posedge clk);
        model_step(r, ld, v, d, lz_en);
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, value, dp_in);
    endtask

    task automatic wait_fd();
        int k;
        k = 0;
        do begin
            idle(1);
            k++;
        end while (!frame_done && k < 2 * TOT);
        if (!frame_done) chk("frame_done timeout", 32'd0, 32'd1);
    endtask

    task automatic run_to_pos(input int p);
        for (int i = 0; i < TOT && m_pos != p; i++) idle(1);
    endtask

    task automatic expect_digit(input int di, input logic [6:0] s, input logic d);
        int k;
        k = 0;
        while (an != ~(4'b1 << di) && k < 2 * TOT) begin
            idle(1);
            k++;
        end
        chk($sformatf("digit%0d anode", di), {28'd0, an}, {28'd0, ~(4'b1 << di)});
        chk($sformatf("digit%0d seg", di), {25'd0, seg}, {25'd0, s});
        chk($sformatf("digit%0d dp", di), {31'd0, dp}, {31'd0, d});
    endtask

    // Scoreboard monitor: compare every registered output sample to the model
    initial begin
        logic [13:0] e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({an, seg, dp, pending, frame_done} !== e) begin
                    n_errors++;
                    $display("FAIL scoreboard t=%0t: got an=%h seg=%h dp=%b pend=%b fd=%b expected an=%h seg=%h dp=%b pend=%b fd=%b",
                             $time, an, seg, dp, pending, frame_done, e[13:10], e[9:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [15:0] v;
        dec = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        m_pos = 0; m_disp = '0; m_ddp = '0; m_sh = '0; m_shdp = '0; m_pend = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0, 4'h0);
        chk("reset an", {28'd0, an}, 32'hF);
        chk("reset seg", {25'd0, seg}, 32'h7F);
        chk("reset dp", {31'd0, dp}, 32'd1);
        chk("reset pending", {31'd0, pending}, 32'd0);
        idle(2);
        chk("first on an", {28'd0, an}, 32'hE);
        chk("first on seg", {25'd0, seg}, 32'h40);

        tick(1'b0, 1'b1, 16'h12AF, 4'b0100);
        chk("pending after load", {31'd0, pending}, 32'd1);
        wait_fd();
        chk("pending after commit", {31'd0, pending}, 32'd0);
        expect_digit(0, 7'h0E, 1'b1);
        expect_digit(1, 7'h08, 1'b1);
        expect_digit(2, 7'h24, 1'b0);
        expect_digit(3, 7'h79, 1'b1);

        lz_en = 1'b1;
        tick(1'b0, 1'b1, 16'h0070, 4'h0);
        wait_fd();
        expect_digit(0, 7'h40, 1'b1);
        expect_digit(1, 7'h78, 1'b1);
        expect_digit(2, 7'h7F, 1'b1);
        expect_digit(3, 7'h7F, 1'b1);
        tick(1'b0, 1'b1, 16'h0000, 4'h0);
        wait_fd();
        expect_digit(0, 7'h40, 1'b1);
        expect_digit(1, 7'h7F, 1'b1);
        lz_en = 1'b0;

        run_to_pos(10);
        tick(1'b0, 1'b1, 16'h3C5B, 4'h0);
        chk("mid-frame pending", {31'd0, pending}, 32'd1);
        wait_fd();
        chk("wrap pending clear", {31'd0, pending}, 32'd0);
        expect_digit(0, 7'h03, 1'b1);

        run_to_pos(5);
        tick(1'b0, 1'b1, 16'h0001, 4'h0);
        run_to_pos(TOT - 1);
        tick(1'b0, 1'b1, 16'h0008, 4'h0);
        chk("wrap-load frame_done", {31'd0, frame_done}, 32'd1);
        chk("wrap-load pending", {31'd0, pending}, 32'd1);
        expect_digit(0, 7'h79, 1'b1);
        wait_fd();
        expect_digit(0, 7'h00, 1'b1);

        run_to_pos(5);
        tick(1'b0, 1'b1, 16'h5555, 4'hF);
        run_to_pos(2 * DIV + 4);
        tick(1'b1, 1'b0, 16'h5555, 4'hF);
        chk("mid rst an", {28'd0, an}, 32'hF);
        chk("mid rst seg", {25'd0, seg}, 32'h7F);
        chk("mid rst dp", {31'd0, dp}, 32'd1);
        chk("mid rst pending", {31'd0, pending}, 32'd0);
        chk("mid rst frame_done", {31'd0, frame_done}, 32'd0);
        wait_fd();
        expect_digit(0, 7'h40, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) lz_en = ~lz_en;
            v = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 19) == 0, v, 4'($urandom));
        end

        @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
